// File: rtl/int_exec_if.sv
// Bundle between dispatch / register file and the integer execution stage.
// intOp!=0 is valid, !intBusy is ready; an op transfers on an edge where both hold.
interface int_exec_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic [3:0]        intOp;
  logic [SEL_W-1:0]  intA;
  logic [SEL_W-1:0]  intB;
  logic [SEL_W-1:0]  intC;
  logic              intBusy;
  logic [SEL_W-1:0]  rfASel;
  logic [SEL_W-1:0]  rfBSel;
  logic [DATA_W-1:0] rfADat;
  logic [DATA_W-1:0] rfBDat;
  logic [SEL_W-1:0]  rfWSel;
  logic [DATA_W-1:0] rfWDat;
  logic              rfWrite;
  logic              flagZ;
  logic              flagN;
  logic              flagC;
  logic              flagV;

  modport master (
    output intOp, intA, intB, intC, rfADat, rfBDat,
    input  intBusy, rfASel, rfBSel, rfWSel, rfWDat, rfWrite,
    input  flagZ, flagN, flagC, flagV
  );

  modport slave (
    input  intOp, intA, intB, intC, rfADat, rfBDat,
    output intBusy, rfASel, rfBSel, rfWSel, rfWDat, rfWrite,
    output flagZ, flagN, flagC, flagV
  );
endinterface

// File: rtl/int_exec_unit.sv
// Integer execution stage: single-cycle ALU/shift ops, a DATA_W-cycle shift-add
// multiply, write-back forwarding and registered condition flags.
module int_exec_unit #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  int_exec_if.slave bus,
  output logic      o_dbg_mul
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int MSB   = DATA_W - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W:0]  W_ONE    = {{DATA_W{1'b0}}, 1'b1};

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_SRA = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_MOV = 4'hC;
  localparam logic [3:0] OP_INC = 4'hD;
  localparam logic [3:0] OP_DEC = 4'hE;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_write;
  logic [SEL_W-1:0]  r_wsel;
  logic [DATA_W-1:0] r_wdat;
  logic              r_z, r_n, r_c, r_v;
  logic [DATA_W-1:0] r_ma;
  logic [DATA_W-1:0] r_mb;
  logic [DATA_W-1:0] r_acc;
  logic [SEL_W-1:0]  r_mc;
  logic [CNT_W-1:0]  r_cnt;

  logic                     w_accept;
  logic [DATA_W-1:0]        w_a, w_b;
  logic [CNT_W-1:0]         w_sh;
  logic [DATA_W:0]          w_add, w_sub, w_inc, w_dec, w_shl, w_shr;
  logic signed [DATA_W:0]   w_sra;
  logic [DATA_W-1:0]        w_res;
  logic                     w_c, w_v, w_wr, w_upd;
  logic                     w_z, w_n;
  logic [DATA_W-1:0]        w_acc_next;

  assign bus.rfASel = bus.intA;
  assign bus.rfBSel = bus.intB;
  assign bus.intBusy = r_busy;
  assign bus.rfWrite = r_write;
  assign bus.rfWSel  = r_wsel;
  assign bus.rfWDat  = r_wdat;
  assign bus.flagZ   = r_z;
  assign bus.flagN   = r_n;
  assign bus.flagC   = r_c;
  assign bus.flagV   = r_v;
  assign o_dbg_mul   = (r_state == S_MUL);

  assign w_accept = (bus.intOp != OP_NOP) && !r_busy;

  // A result still on the write port has not reached the register file yet.
  assign w_a = (r_write && (r_wsel == bus.intA)) ? r_wdat : bus.rfADat;
  assign w_b = (r_write && (r_wsel == bus.intB)) ? r_wdat : bus.rfBDat;
  assign w_sh = w_b[CNT_W-1:0];

  // The extra bit of each shift vector captures the last bit shifted out.
  assign w_add = {1'b0, w_a} + {1'b0, w_b};
  assign w_sub = {1'b0, w_a} - {1'b0, w_b};
  assign w_inc = {1'b0, w_a} + W_ONE;
  assign w_dec = {1'b0, w_a} - W_ONE;
  assign w_shl = {1'b0, w_a} << w_sh;
  assign w_shr = {w_a, 1'b0} >> w_sh;
  assign w_sra = $signed({w_a, 1'b0}) >>> w_sh;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_wr  = 1'b0;
    w_upd = 1'b0;
    case (bus.intOp)
      OP_ADD: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[DATA_W];
        w_v   = (w_a[MSB] == w_b[MSB]) && (w_add[MSB] != w_a[MSB]);
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[DATA_W];
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_sub[MSB] != w_a[MSB]);
        w_wr  = (bus.intOp == OP_SUB);
        w_upd = 1'b1;
      end
      OP_AND: begin
        w_res = w_a & w_b;
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_OR: begin
        w_res = w_a | w_b;
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_XOR: begin
        w_res = w_a ^ w_b;
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_NOT: begin
        w_res = ~w_a;
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_SHL: begin
        w_res = w_shl[MSB:0];
        w_c   = w_shl[DATA_W];
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_SHR: begin
        w_res = w_shr[DATA_W:1];
        w_c   = w_shr[0];
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_SRA: begin
        w_res = w_sra[DATA_W:1];
        w_c   = w_sra[0];
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_MOV: begin
        w_res = w_a;
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_INC: begin
        w_res = w_inc[MSB:0];
        w_c   = w_inc[DATA_W];
        w_v   = !w_a[MSB] && w_inc[MSB];
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      OP_DEC: begin
        w_res = w_dec[MSB:0];
        w_c   = w_dec[DATA_W];
        w_v   = w_a[MSB] && !w_dec[MSB];
        w_wr  = 1'b1;
        w_upd = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign w_z = (w_res == '0);
  assign w_n = w_res[MSB];

  // One partial product per cycle: multiplicand walks left, multiplier walks right.
  assign w_acc_next = r_acc + (r_mb[0] ? r_ma : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_write <= 1'b0;
      r_wsel  <= '0;
      r_wdat  <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_mc    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_write <= 1'b0;
          if (w_accept) begin
            if (bus.intOp == OP_MUL) begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
              r_ma    <= w_a;
              r_mb    <= w_b;
              r_mc    <= bus.intC;
              r_acc   <= '0;
              r_cnt   <= '0;
            end else if (w_upd) begin
              r_write <= w_wr;
              r_wsel  <= bus.intC;
              r_wdat  <= w_res;
              r_z     <= w_z;
              r_n     <= w_n;
              r_c     <= w_c;
              r_v     <= w_v;
            end
          end
        end
        S_MUL: begin
          r_write <= 1'b0;
          r_acc   <= w_acc_next;
          r_ma    <= r_ma << 1;
          r_mb    <= r_mb >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_write <= 1'b1;
            r_wsel  <= r_mc;
            r_wdat  <= w_acc_next;
            r_z     <= (w_acc_next == '0);
            r_n     <= w_acc_next[MSB];
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/int_exec_unit.md
Name: int_exec_unit

Overview:
- Integer execution stage directly downstream of the dispatch unit.
- Consumes the dispatch unit's intOp/intA/intB/intC bundle and reads two source registers from the shared 8x16 register file.
- Computes ALU, shift or iterative-multiply results, writes the result back to register intC and updates condition flags.
- Stalls dispatch with intBusy while a multi-cycle multiply is in progress.

Parameters:
- DATA_W, 16, datapath and register width.
- SEL_W, 3, register-select width (8 registers).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- intOp  in  4  opcode from dispatch; 0 = NOP.
- intA  in  SEL_W  source A register index.
- intB  in  SEL_W  source B register index.
- intC  in  SEL_W  destination register index.
- intBusy  out  1  registered; high = op not accepted, dispatch holds its bundle.
- rfASel  out  SEL_W  combinational, equals intA.
- rfBSel  out  SEL_W  combinational, equals intB.
- rfADat  in  DATA_W  register file read data A, combinational read.
- rfBDat  in  DATA_W  register file read data B, combinational read.
- rfWSel  out  SEL_W  write-back register index.
- rfWDat  out  DATA_W  write-back data.
- rfWrite  out  1  one-cycle write strobe; the register file writes on the next edge.
- flagZ, flagN, flagC, flagV  out  1 each  registered condition flags.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All outputs go to 0 except rfASel/rfBSel, which follow the inputs.
  - FSM returns to IDLE and the multiply counter clears.
  - Reset during MUL aborts it: no write-back, flags unchanged from 0.
- Accept condition: intOp!=0 && !intBusy, sampled at the edge. Inputs are ignored while intBusy=1.
- Forwarding:
  - If rfWrite=1 and rfWSel==intA in the accept cycle, operand A = rfWDat instead of rfADat.
  - Same rule for B.
  - Back-to-back dependent ops therefore need no stall.
- Opcodes (A, B = operands; result is DATA_W bits, wrap-around):
  - 1 ADD: A+B.
  - 2 SUB: A-B.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 NOT A.
  - 7 SHL: A<<B[3:0].
  - 8 SHR: logical shift right.
  - 9 SRA: arithmetic shift right.
  - A MUL: low DATA_W bits of A*B.
  - B CMP: A-B, flags only, no write.
  - C MOV: A.
  - D INC: A+1.
  - E DEC: A-1.
  - F: treated as NOP.
- Flags:
  - Z and N update on every accepted op except NOP/F.
  - ADD, INC: C = carry out; V = signed overflow.
  - SUB, DEC, CMP: C = borrow (A<B unsigned); V = signed overflow.
  - Shifts: C = last bit shifted out; shift amount 0 gives C=0. V=0.
  - Logic ops, MOV and MUL: C=0, V=0.
- Single-cycle ops (everything except MUL):
  - Accepted at edge E0.
  - After E0: rfWrite=1 (0 for CMP), rfWSel=intC, rfWDat=result, flags updated.
  - The register file commits at E1; rfWrite drops after E1 unless a new op was accepted at E1.
- MUL state machine, states IDLE, MUL:
  - IDLE: on accepting op A, latch A, B and intC, clear accumulator and counter, go to MUL, intBusy=1 after E0.
  - MUL: one shift-add step per edge; the counter runs 0..DATA_W-1.
  - On the edge with counter==DATA_W-1: go to IDLE, intBusy=0, rfWrite=1 with the product, flags Z/N updated.
  - Total: intBusy high for exactly DATA_W cycles; result write strobe DATA_W cycles after accept.
  - A new op may be accepted on the first IDLE cycle, forwarding the product if dependent.
- A NOP while idle produces no write and leaves the flags unchanged.
- A write-back to register 0 is an ordinary write; no register is hardwired.

Test Plan:
1. Reset held 3 cycles with intOp=1 driven -> all outputs 0, no rfWrite; after release, ADD r1=0x0005, r2=0x0003 into r3 -> rfWrite=1, rfWSel=3, rfWDat=0x0008 one cycle later, Z=N=C=V=0.
2. ADD 0x7FFF+0x0001 -> 0x8000, N=1, V=1, C=0; ADD 0xFFFF+0x0001 -> 0x0000, Z=1, C=1, V=0.
3. Back-to-back ADD r3=r1+r2 then SUB r4=r3-r1 (r1=5, r2=3) -> second result 0x0003 via forwarding, no stall; CMP 3,5 -> no rfWrite, C=1, N=1.
4. MUL 0x0123*0x0010 -> intBusy high 16 cycles, then rfWDat=0x1230; a MUL bundle held by dispatch throughout is executed exactly once.
5. SHL 0x8001 by 1 -> 0x0002, C=1; SRA 0x8000 by 15 -> 0xFFFF; SHR 0x8000 by 0 -> 0x8000, C=0.
6. rst_n pulled low at multiply cycle 7 -> no rfWrite, intBusy=0 after the edge; a subsequent INC 0xFFFF -> 0x0000, Z=1, C=1.
